vga_pixel_fetch: RTL

VGA_PIXEL_FETCH -- requirements
Module: vga_pixel_fetch

---
 rtl/vga_pkg.sv | 43 ++++
 rtl/pipe_delay.sv | 32 +++
 rtl/vga_pixel_fetch.sv | 102 ++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared constants, pipeline payload types and background address helper for the pixel fetch path.
// Latency: n/a (package only).  Backpressure: n/a.
package vga_pkg;

    localparam int ADDR_W     = 17;
    localparam int COLOUR_W   = 12;
    localparam int SCREEN_W   = 320;
    localparam int BG_SIZE    = 76800;
    localparam int PIPE_DEPTH = 2;

    localparam logic [COLOUR_W-1:0] KEY_COLOUR = 12'hFFF;

    typedef enum logic [3:0] {
        PIC_BACK = 4'd0,
        PIC_P1   = 4'd1,
        PIC_P2   = 4'd2,
        PIC_BALL = 4'd3
    } pic_e;

    typedef struct packed {
        logic [3:0] pic;
        logic       vld;
    } ctrl_t;

    typedef struct packed {
        logic hs;
        logic vs;
    } sync_t;

    // Background is 320x240 upscaled 2x; the linear index can reach ~2.1x BG_SIZE
    // for out-of-range counters, so at most two subtractions bring it into range.
    function automatic logic [ADDR_W-1:0] bg_addr_calc(input logic [9:0] h, input logic [9:0] v);
        logic [17:0] lin;
        lin = 18'(v >> 1) * 18'(SCREEN_W) + 18'(h >> 1);
        if (lin >= 18'(2 * BG_SIZE)) begin
            lin = lin - 18'(2 * BG_SIZE);
        end else if (lin >= 18'(BG_SIZE)) begin
            lin = lin - 18'(BG_SIZE);
        end
        return ADDR_W'(lin);
    endfunction

endpackage

// File: rtl/pipe_delay.sv
// Generic shift-register delay line advancing only when en is high.
// Latency: DEPTH en-qualified clk edges.  Backpressure: none; en low holds every stage.
module pipe_delay #(
    parameter int            W       = 1,
    parameter int            DEPTH   = 2,
    parameter logic [W-1:0]  RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    logic [W-1:0] stage_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= RST_VAL;
            end
        end else if (en) begin
            stage_q[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_pixel_fetch.sv
// Background/sprite ROM address generation and colour select; TRANSPARENCY_EN keys out 12'hFFF sprite pixels.
// Latency: 2 pixel edges (pclk_en-qualified clk) from counters/syncs to colour and syncs.
// Backpressure: none; pclk_en low freezes the whole pipeline.
module vga_pixel_fetch
    import vga_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                pclk_en,
    input  logic [9:0]          h_cnt,
    input  logic [9:0]          v_cnt,
    input  logic                valid_in,
    input  logic                hsync_in,
    input  logic                vsync_in,
    input  logic [ADDR_W-1:0]   pixel_addr,
    input  logic [3:0]          pic_choice,
    output logic [ADDR_W-1:0]   bg_addr,
    output logic [ADDR_W-1:0]   spr_addr,
    input  logic [COLOUR_W-1:0] bg_data,
    input  logic [COLOUR_W-1:0] p1_data,
    input  logic [COLOUR_W-1:0] p2_data,
    input  logic [COLOUR_W-1:0] ball_data,
    output logic [3:0]          vgaRed,
    output logic [3:0]          vgaGreen,
    output logic [3:0]          vgaBlue,
    output logic                hsync,
    output logic                vsync
);

    ctrl_t                ctrl_in;
    ctrl_t                s1_ctrl;
    sync_t                sync_in;
    sync_t                sync_out;
    logic [COLOUR_W-1:0]  colour_sel;
    logic [COLOUR_W-1:0]  colour_q;

    assign ctrl_in = '{pic: pic_choice, vld: valid_in};
    assign sync_in = '{hs: hsync_in, vs: vsync_in};

    // Source select and valid travel one stage alongside the ROM addresses.
    pipe_delay #(
        .W       ($bits(ctrl_t)),
        .DEPTH   (PIPE_DEPTH - 1),
        .RST_VAL ('0)
    ) u_ctrl_delay (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (pclk_en),
        .din   (ctrl_in),
        .dout  (s1_ctrl)
    );

    // Syncs idle high out of reset and ride the full depth to meet the colour register.
    pipe_delay #(
        .W       ($bits(sync_t)),
        .DEPTH   (PIPE_DEPTH),
        .RST_VAL ('1)
    ) u_sync_delay (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (pclk_en),
        .din   (sync_in),
        .dout  (sync_out)
    );

    assign hsync = sync_out.hs;
    assign vsync = sync_out.vs;

    always_comb begin
        colour_sel = bg_data;
        case (s1_ctrl.pic)
            PIC_BACK: colour_sel = bg_data;
            PIC_P1:   colour_sel = p1_data;
            PIC_P2:   colour_sel = p2_data;
            PIC_BALL: colour_sel = ball_data;
            default:  colour_sel = bg_data;
        endcase
`ifdef TRANSPARENCY_EN
        if ((s1_ctrl.pic inside {PIC_P1, PIC_P2, PIC_BALL}) && (colour_sel == KEY_COLOUR)) begin
            colour_sel = bg_data;
        end
`endif
    end

    // Background address ignores pic_choice so it is always ready behind a sprite.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bg_addr  <= '0;
            spr_addr <= '0;
            colour_q <= '0;
        end else if (pclk_en) begin
            bg_addr  <= bg_addr_calc(h_cnt, v_cnt);
            spr_addr <= pixel_addr;
            colour_q <= s1_ctrl.vld ? colour_sel : '0;
        end
    end

    assign vgaRed   = colour_q[11:8];
    assign vgaGreen = colour_q[7:4];
    assign vgaBlue  = colour_q[3:0];

endmodule
